// File: rtl/fetch_stage.sv
// fetch_stage: MIPS IF stage holding the PC and the IF/ID register, with freeze and branch flush.
// Define FETCH_PERF_CNT_EN to add fetch/stall/flush event counters.
module fetch_stage #(
  parameter int WORD_LEN = 32,
  parameter logic [WORD_LEN-1:0] RESET_PC = '0,
  parameter logic [WORD_LEN-1:0] NOP_WORD = 32'h00000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  input  logic                branch_taken,
  input  logic [WORD_LEN-1:0] branch_addr,
  output logic [WORD_LEN-1:0] instr_addr,
  input  logic [WORD_LEN-1:0] instr_in,
  output logic [WORD_LEN-1:0] ifid_pc,
  output logic [WORD_LEN-1:0] ifid_instr,
`ifdef FETCH_PERF_CNT_EN
  output logic [WORD_LEN-1:0] perf_fetch_cnt,
  output logic [WORD_LEN-1:0] perf_stall_cnt,
  output logic [WORD_LEN-1:0] perf_flush_cnt,
`endif
  output logic                ifid_valid
);
  logic [WORD_LEN-1:0] pc_q, pc_d, pc_plus4;
  logic [WORD_LEN-1:0] ifid_pc_q, ifid_pc_d, ifid_instr_q, ifid_instr_d;
  logic                ifid_valid_q, ifid_valid_d;
  logic                normal, hold;
  always_comb begin
    pc_plus4     = pc_q + WORD_LEN'(4);
    normal       = !branch_taken && !freeze;
    hold         = !branch_taken && freeze;
    pc_d         = branch_taken ? {branch_addr[WORD_LEN-1:2], 2'b00} : hold ? pc_q : pc_plus4;
    ifid_instr_d = branch_taken ? NOP_WORD : hold ? ifid_instr_q : instr_in;
    ifid_pc_d    = branch_taken ? '0 : hold ? ifid_pc_q : pc_plus4;
    ifid_valid_d = branch_taken ? 1'b0 : hold ? ifid_valid_q : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= {RESET_PC[WORD_LEN-1:2], 2'b00};
      ifid_instr_q <= NOP_WORD;
      ifid_pc_q    <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end
  assign instr_addr = pc_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_instr = ifid_instr_q;
  assign ifid_valid = ifid_valid_q;
`ifdef FETCH_PERF_CNT_EN
  // Exactly one of the three events occurs on every non-reset edge.
  logic [WORD_LEN-1:0] fetch_cnt_q, fetch_cnt_d, stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  always_comb begin
    fetch_cnt_d = fetch_cnt_q + WORD_LEN'(normal);
    stall_cnt_d = stall_cnt_q + WORD_LEN'(hold);
    flush_cnt_d = flush_cnt_q + WORD_LEN'(branch_taken);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table plus a reset-during-freeze sequence for fetch_stage.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h00000000;
  logic clk = 1'b0, rst = 1'b1, freeze = 1'b0, branch_taken = 1'b0;
  logic [31:0] branch_addr = '0, instr_addr, instr_in, ifid_pc, ifid_instr;
  logic ifid_valid;
  int tests = 0, failed = 0;
  logic [31:0] e_fetch = 0, e_stall = 0, e_flush = 0;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt;
`endif
  fetch_stage dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .instr_addr(instr_addr), .instr_in(instr_in),
    .ifid_pc(ifid_pc), .ifid_instr(ifid_instr),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
`endif
    .ifid_valid(ifid_valid)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] w(input logic [31:0] a);
    return 32'hC0DE0000 ^ {a[15:0], a[15:0]};
  endfunction
  assign instr_in = w(instr_addr);
  typedef struct {
    logic rst, frz, br;
    logic [31:0] baddr, addr, ipc, instr;
    logic valid;
  } vec_t;
  vec_t v[18];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step(input logic r, input logic f, input logic b, input logic [31:0] ba);
    rst = r; freeze = f; branch_taken = b; branch_addr = ba;
    @(posedge clk);
    if (r) begin e_fetch = 0; e_stall = 0; e_flush = 0; end
    else if (b) e_flush++;
    else if (f) e_stall++;
    else e_fetch++;
    #1;
  endtask
  task automatic chk_all(input string tag, input logic [31:0] a, input logic [31:0] p,
                         input logic [31:0] i, input logic val);
    chk({tag, ".instr_addr"}, instr_addr, a);
    chk({tag, ".ifid_pc"}, ifid_pc, p);
    chk({tag, ".ifid_instr"}, ifid_instr, i);
    chk({tag, ".ifid_valid"}, {31'b0, ifid_valid}, {31'b0, val});
`ifdef FETCH_PERF_CNT_EN
    chk({tag, ".perf_fetch"}, perf_fetch_cnt, e_fetch);
    chk({tag, ".perf_stall"}, perf_stall_cnt, e_stall);
    chk({tag, ".perf_flush"}, perf_flush_cnt, e_flush);
`endif
  endtask
  initial begin
    v[0]  = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, NOP, 1'b0};
    v[1]  = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, NOP, 1'b0};
    v[2]  = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h4, 32'h4, w(32'h0), 1'b1};
    v[3]  = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h8, 32'h8, w(32'h4), 1'b1};
    v[4]  = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h8, 32'h8, w(32'h4), 1'b1};
    v[5]  = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h8, 32'h8, w(32'h4), 1'b1};
    v[6]  = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h8, 32'h8, w(32'h4), 1'b1};
    v[7]  = '{1'b0, 1'b0, 1'b0, 32'h0, 32'hC, 32'hC, w(32'h8), 1'b1};
    v[8]  = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h10, 32'h10, w(32'hC), 1'b1};
    v[9]  = '{1'b0, 1'b0, 1'b1, 32'h40, 32'h40, 32'h0, NOP, 1'b0};
    v[10] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h44, 32'h44, w(32'h40), 1'b1};
    v[11] = '{1'b0, 1'b1, 1'b1, 32'h23, 32'h20, 32'h0, NOP, 1'b0};
    v[12] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h24, 32'h24, w(32'h20), 1'b1};
    v[13] = '{1'b0, 1'b0, 1'b1, 32'h13, 32'h10, 32'h0, NOP, 1'b0};
    v[14] = '{1'b0, 1'b0, 1'b1, 32'h10, 32'h10, 32'h0, NOP, 1'b0};
    v[15] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h14, 32'h14, w(32'h10), 1'b1};
    v[16] = '{1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFC, 32'h0, NOP, 1'b0};
    v[17] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, w(32'hFFFFFFFC), 1'b1};
    @(negedge clk);
    for (int k = 0; k < 18; k++) begin
      step(v[k].rst, v[k].frz, v[k].br, v[k].baddr);
      chk_all($sformatf("v%0d", k), v[k].addr, v[k].ipc, v[k].instr, v[k].valid);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h30);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk_all("frz_at_30", 32'h30, 32'h0, NOP, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'h80);
    chk_all("rst_mid_frz", 32'h0, 32'h0, NOP, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk_all("post_rst", 32'h4, 32'h4, w(32'h0), 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
